// File: rtl/myriadrf_rx_capture_ctrl.sv
// Capture sequencer from the MyriadRF RX IQ stream into a small ready/valid FIFO.
// Arms on command, optionally waits for a trigger edge, decimates and counts a burst.
module myriadrf_rx_capture_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [15:0] cfg_len,
  input  logic [7:0]  cfg_decim,
  input  logic        cfg_trig_en,
  input  logic        trig_i,
  input  logic [23:0] s_data_i,
  input  logic        s_valid_i,
  output logic [23:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [15:0] count_o
);

  // state   | meaning
  // IDLE    | waiting for cfg_start
  // ARMED   | started, waiting for a trig_i rising edge
  // CAPTURE | keeping decimated samples into the FIFO
  // DRAIN   | burst complete, waiting for the FIFO to empty
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [15:0]   len_q;
  logic [7:0]    decim_q;
  logic [7:0]    decim_cnt;
  logic          trig_q;
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;

  logic          trig_edge;
  logic          pop;
  logic          full;
  logic          keep;
  logic          push;
  logic          is_last;
  logic [15:0]   count_inc;

  always_comb begin
    trig_edge = trig_i & ~trig_q;
    pop       = m_valid_o & m_ready_i;
    full      = (fcnt == FULL_CNT);
    keep      = (state == CAPTURE) & s_valid_i & (decim_cnt == 8'd0) & ~cfg_abort;
    count_inc = count_o + 16'd1;
    is_last   = (len_q != 16'd0) & (count_inc == len_q);
    // a pop in the same cycle frees the slot for a push into a full FIFO
    push      = keep & (~full | pop);
  end

  assign m_valid_o = (fcnt != '0);
  assign m_data_o  = mem[rd_ptr][23:0];
  assign m_last_o  = m_valid_o & mem[rd_ptr][24];
  assign busy_o    = (state != IDLE);

  // reset to 1 so a trigger already high out of reset is not seen as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b1;
    else     trig_q <= trig_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      decim_q   <= '0;
      decim_cnt <= '0;
      count_o   <= '0;
      ovf_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (cfg_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              len_q     <= cfg_len;
              decim_q   <= cfg_decim;
              decim_cnt <= '0;
              count_o   <= '0;
              ovf_o     <= 1'b0;
              state     <= cfg_trig_en ? ARMED : CAPTURE;
            end
          end
          ARMED: begin
            if (trig_edge) state <= CAPTURE;
          end
          CAPTURE: begin
            if (s_valid_i) decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
            if (keep) begin
              count_o <= count_inc;
              if (!push) ovf_o <= 1'b1;
              if (is_last) state <= DRAIN;
            end
          end
          default: begin
            if ((fcnt == '0) || ((fcnt == CW'(1)) && pop)) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (cfg_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {is_last, s_data_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_myriadrf_rx_capture_ctrl.sv
// Bench for myriadrf_rx_capture_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_myriadrf_rx_capture_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_decim = '0;
  logic        cfg_trig_en = 1'b0;
  logic        trig_i = 1'b0;
  logic [23:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;
  logic [15:0] count_o;

  always #5 clk = ~clk;

  myriadrf_rx_capture_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_len(cfg_len), .cfg_decim(cfg_decim), .cfg_trig_en(cfg_trig_en),
    .trig_i(trig_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
    .count_o(count_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // behavioural model: mode 0 idle, 1 armed, 2 capture, 3 drain
  logic [24:0] mq[$];
  int          md_mode;
  logic [15:0] md_len;
  logic [15:0] md_count;
  logic [7:0]  md_decim;
  int          md_nvalid;
  logic        md_ovf;
  logic        md_done;
  logic        md_trig_prev;

  function automatic void model_reset();
    mq.delete();
    md_mode = 0; md_len = '0; md_count = '0; md_decim = '0;
    md_nvalid = 0; md_ovf = 1'b0; md_done = 1'b0; md_trig_prev = 1'b1;
  endfunction

  function automatic void model_step();
    logic pop, edge_seen, keep, last;
    pop = (mq.size() != 0) && m_ready_i;
    edge_seen = trig_i && !md_trig_prev;
    md_trig_prev = trig_i;
    md_done = 1'b0;
    if (cfg_abort) begin
      mq.delete();
      md_mode = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      case (md_mode)
        0: if (cfg_start) begin
          md_len = cfg_len; md_decim = cfg_decim; md_count = '0;
          md_ovf = 1'b0; md_nvalid = 0;
          md_mode = cfg_trig_en ? 1 : 2;
        end
        1: if (edge_seen) md_mode = 2;
        2: if (s_valid_i) begin
          keep = (md_nvalid % (int'(md_decim) + 1)) == 0;
          md_nvalid++;
          if (keep) begin
            md_count = md_count + 16'd1;
            last = (md_len != 16'd0) && (md_count == md_len);
            if (mq.size() < DEPTH) mq.push_back({last, s_data_i});
            else md_ovf = 1'b1;
            if (last) md_mode = 3;
          end
        end
        default: if (mq.size() == 0) begin
          md_mode = 0;
          md_done = 1'b1;
        end
      endcase
    end
  endfunction

  function automatic logic [44:0] exp_vec();
    logic v;
    logic [24:0] h;
    v = (mq.size() != 0);
    h = '0;
    if (v) h = mq[0];
    return {v, h[24], h[23:0], md_mode != 0, md_done, md_ovf, md_count};
  endfunction

  function automatic logic [44:0] dut_vec();
    return {m_valid_o, m_valid_o ? m_last_o : 1'b0, m_valid_o ? m_data_o : 24'h0,
            busy_o, done_o, ovf_o, count_o};
  endfunction

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_cap(input logic [15:0] len, input logic [7:0] decim, input logic ten);
    cfg_len = len; cfg_decim = decim; cfg_trig_en = ten;
    cfg_start = 1'b1; s_valid_i = 1'b0;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_data_o, m_valid_o, m_last_o, busy_o, done_o, ovf_o, count_o} !== 45'h0) begin
      miscompares++;
      $display("FAIL reset_values got=%h exp=0", {m_data_o, m_valid_o, m_last_o, busy_o, done_o, ovf_o, count_o});
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    int last_cyc = -1, done_cyc = -1;
    m_ready_i = 1'b1;
    start_cap(16'd4, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s_valid_i = (i < 8);
      s_data_i = 24'(i + 1);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (m_valid_o && m_last_o) last_cyc = cyc;
      if (done_o) done_cyc = cyc;
    end
    s_valid_i = 1'b0;
    vectors++;
    if ({count_o, ovf_o} !== {16'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_count got=%h exp=%h", {count_o, ovf_o}, {16'd4, 1'b0});
    end
    vectors++;
    if (last_cyc < 0 || done_cyc != last_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_decim();
    logic [24:0] got[$];
    m_ready_i = 1'b1;
    start_cap(16'd3, 8'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      s_valid_i = (i < 9);
      s_data_i = 24'(i + 1);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL decim cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (m_valid_o && m_ready_i) got.push_back({m_last_o, m_data_o});
    end
    s_valid_i = 1'b0;
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL decim_len got=%0d exp=3", got.size());
    end else if ({got[0], got[1], got[2]} !== {25'h0000001, 25'h0000004, 25'h1000007}) begin
      miscompares++;
      $display("FAIL decim_seq got=%h exp=%h", {got[0], got[1], got[2]},
               {25'h0000001, 25'h0000004, 25'h1000007});
    end
  endtask

  task automatic test_trigger();
    m_ready_i = 1'b1;
    trig_i = 1'b0;
    start_cap(16'd2, 8'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      s_valid_i = 1'b1;
      s_data_i = 24'h100 + 24'(i);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || m_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL trig_wait cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    trig_i = 1'b1;
    s_data_i = 24'h200;
    tick();
    s_data_i = 24'h201;
    tick();
    vectors++;
    if ({m_valid_o, m_data_o} !== {1'b1, 24'h201}) begin
      miscompares++;
      $display("FAIL trig_first got=%h exp=%h", {m_valid_o, m_data_o}, {1'b1, 24'h201});
    end
    for (int i = 0; i < 4; i++) begin
      s_data_i = 24'h202 + 24'(i);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL trig_run cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    s_valid_i = 1'b0;
    trig_i = 1'b0;
  endtask

  task automatic test_overflow();
    int npop = 0, nlast = 0, ndone = 0;
    m_ready_i = 1'b0;
    start_cap(16'd6, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      s_valid_i = (i < 6);
      s_data_i = 24'h300 + 24'(i + 1);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_fill cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    s_valid_i = 1'b0;
    vectors++;
    if ({count_o, ovf_o, m_valid_o, busy_o} !== {16'd6, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_state got=%h exp=%h", {count_o, ovf_o, m_valid_o, busy_o},
               {16'd6, 1'b1, 1'b1, 1'b1});
    end
    m_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (m_valid_o) begin
        npop++;
        if (m_last_o) nlast++;
      end
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (done_o) ndone++;
    end
    vectors++;
    if ({npop, nlast, ndone} !== {32'd4, 32'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL ovf_summary got=%0d/%0d/%0d exp=4/0/1", npop, nlast, ndone);
    end
  endtask

  task automatic test_abort();
    m_ready_i = 1'b1;
    start_cap(16'd0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i = 24'h400 + 24'(i);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL abort_run cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    s_data_i = 24'h4ff;
    tick();
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    vectors++;
    if ({m_valid_o, busy_o, done_o, count_o} !== {1'b0, 1'b0, 1'b0, 16'd6}) begin
      miscompares++;
      $display("FAIL abort_now got=%h exp=%h", {m_valid_o, busy_o, done_o, count_o},
               {1'b0, 1'b0, 1'b0, 16'd6});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || busy_o !== 1'b0 || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic test_async_reset();
    m_ready_i = 1'b0;
    start_cap(16'd0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i = 24'h500 + 24'(i);
      tick();
    end
    s_valid_i = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || m_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre got=%h exp=%h", dut_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({m_data_o, m_valid_o, m_last_o, busy_o, done_o, ovf_o, count_o} !== 45'h0) begin
      miscompares++;
      $display("FAIL areset_immediate got=%h exp=0", {m_data_o, m_valid_o, m_last_o, busy_o, done_o, ovf_o, count_o});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      cfg_len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      cfg_decim = 8'($urandom_range(0, 3));
      cfg_trig_en = 1'($urandom_range(0, 1));
      cfg_start = ($urandom_range(0, 5) == 0);
      cfg_abort = ($urandom_range(0, 149) == 0);
      s_valid_i = ($urandom_range(0, 3) != 0);
      s_data_i = 24'($urandom);
      m_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) trig_i = ~trig_i;
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    s_valid_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_decim();
    test_trigger();
    test_overflow();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/myriadrf_rx_capture_ctrl.md
# myriadrf_rx_capture_ctrl

Capture sequencer between the MyriadRF RX interface and the downstream sample sink. It takes the free-running 24-bit IQ stream (no backpressure available upstream), arms on software command, optionally waits for an external trigger, decimates, and counts a programmed burst of samples. It buffers them in a 4-entry FIFO toward a ready/valid master port and reports completion, sample count and overflow.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries (power of two, ≥2).
- `clk` in 1: system clock, the single clock domain.
- `rst` in 1: reset; asynchronous, active-high.
- `cfg_start` in 1: one-cycle pulse; starts a capture; ignored while `busy_o`=1.
- `cfg_abort` in 1: one-cycle pulse; aborts from any state.
- `cfg_len` in 16: kept samples per burst; 0 = continuous.
- `cfg_decim` in 8: keep 1 of every `cfg_decim+1` valid samples.
- `cfg_trig_en` in 1: 1 = wait for trigger rising edge after start.
- `trig_i` in 1: external trigger level, synchronous to `clk`.
- `s_data_i` in 24: IQ sample, Q in [23:12], I in [11:0].
- `s_valid_i` in 1: sample strobe; no ready is returned.
- `m_data_o` out 24: buffered sample.
- `m_valid_o` out 1: `m_data_o` valid.
- `m_ready_i` in 1: sink accepts when `m_valid_o & m_ready_i`.
- `m_last_o` out 1: marks final sample of a finite burst.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle pulse when a finite burst completes and drains.
- `ovf_o` out 1: sticky; a kept sample was dropped on a full FIFO.
- `count_o` out 16: kept samples in the current or last burst.

## Operation
- On start, `cfg_len`, `cfg_decim` and `cfg_trig_en` are latched. Later changes have no effect until the next start.
- States:
  - IDLE: `cfg_start` → ARMED if `cfg_trig_en`=1, else CAPTURE. A start clears `count_o`, `ovf_o` and the decimation counter.
  - ARMED: trigger edge (`trig_i`=1 and its registered copy = 0) → CAPTURE. The edge detector register resets to 1, so a high level at reset is not an edge.
  - CAPTURE: on each `s_valid_i`, keep the sample if decim_cnt = 0.
    - decim_cnt advances to `cfg_decim`, then wraps to 0. The first valid sample in CAPTURE is always kept.
    - A kept sample increments `count_o` and is pushed with last = (len≠0 and count_o+1 = len).
    - After pushing last → DRAIN.
    - If len = 0, `count_o` wraps 65535→0 and the state never leaves CAPTURE except by abort.
  - DRAIN: FIFO empty → IDLE with `done_o`=1 for that cycle.
- Overflow:
  - A kept sample arriving when the FIFO is full and no pop occurs that cycle is dropped. It still counts, and `ovf_o` is set.
  - If the dropped sample is the last one, the state still goes to DRAIN, `done_o` still fires, and no `m_last_o` is emitted.
- Push and pop in the same cycle on a full FIFO: the pop frees the slot and the push succeeds.
- Abort: in any state → IDLE next cycle. The FIFO is flushed, `m_valid_o` is 0 from the next cycle, and no `done_o` is generated. `count_o` and `ovf_o` hold.
- `cfg_abort` and `cfg_start` in the same cycle: abort wins and the start is discarded.
- Samples arriving in IDLE, ARMED or DRAIN are discarded.

## Timing
- Reset values: `m_data_o`=0, `m_valid_o`=0, `m_last_o`=0, `busy_o`=0, `done_o`=0, `ovf_o`=0, `count_o`=0, state IDLE, FIFO empty, decim_cnt=0.
- `busy_o` rises the cycle after `cfg_start`. CAPTURE with no trigger is active from that cycle, so `s_valid_i` one cycle after start is eligible.
- Trigger edge on `trig_i` at cycle T: CAPTURE from T+1. Samples at T are discarded.
- Latency: a sample kept at cycle N appears on `m_valid_o`/`m_data_o` at N+1 with an empty FIFO. All outputs are registered.
- `count_o` updates at N+1.
- `m_data_o`/`m_last_o` hold while `m_valid_o & !m_ready_i`.
- `done_o`: the cycle after the final pop empties the FIFO.
- `busy_o` falls together with `done_o`.

## Test plan
- No trigger, len=4, decim=0, `m_ready_i`=1, valid every cycle with data 0x000001..:
  - Outputs 0x000001–0x000004, one per cycle starting one cycle after each input.
  - `m_last_o` on 0x000004, `done_o` one cycle after its pop, `count_o`=4, `ovf_o`=0.
- Decim=2, len=3, inputs 1..9 → outputs 1, 4, 7; `m_last_o` on 7.
- Trigger enabled, start, valid samples for 10 cycles with `trig_i`=0:
  - No output during those cycles.
  - Raise `trig_i` at cycle T: the first output is the sample from T+1.
- `m_ready_i`=0, len=6, continuous valid:
  - Four samples buffered; samples 5 and 6 dropped; `ovf_o`=1; `count_o`=6.
  - Release ready: 4 outputs, no `m_last_o`, then `done_o`.
- len=0, mid-stream `cfg_abort` together with `cfg_start`:
  - `m_valid_o`=0 next cycle, `busy_o`=0, no `done_o`, new start ignored.
- Assert `rst` asynchronously mid-capture with a full FIFO → all outputs at their reset values immediately, before the next clock edge.
